// File: rtl/bcd_serial_adder_ctrl.sv
// bcd_serial_adder_ctrl: digit-serial packed-BCD adder sharing one digit adder and one >9 comparator; BCD_SUB_EN adds nine's-complement subtract
module bcd_serial_adder_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                cin,
`ifdef BCD_SUB_EN
    input  logic                sub,
`endif
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout,
    output logic                err
);
    localparam int W  = 4 * DIGITS;
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
    state_t        r_state;
    logic [W-1:0]  r_a, r_b, r_sum;
    logic [IW-1:0] r_idx;
    logic          r_c, r_cout, r_err, r_busy, r_done;
    logic [3:0]    w_a_d, w_b_d, w_b_e, w_s;
    logic [4:0]    w_t;
    logic          w_gt9, w_bad, w_last;
    function automatic logic above9(input logic [4:0] v);
        return v[4] | (v[3] & (v[2] | v[1]));
    endfunction
    assign w_a_d = 4'(r_a >> {r_idx, 2'b00});
    assign w_b_d = 4'(r_b >> {r_idx, 2'b00});
`ifdef BCD_SUB_EN
    logic r_sub;
    assign w_b_e = r_sub ? 4'd9 - w_b_d : w_b_d;
`else
    assign w_b_e = w_b_d;
`endif
    assign w_t    = {1'b0, w_a_d} + {1'b0, w_b_e} + {4'b0, r_c};
    assign w_gt9  = above9(w_t);
    assign w_s    = w_gt9 ? w_t[3:0] + 4'd6 : w_t[3:0];
    assign w_bad  = above9({1'b0, w_a_d}) | above9({1'b0, w_b_d});
    assign w_last = r_idx == IW'(DIGITS - 1);
    assign busy   = r_busy;
    assign done   = r_done;
    assign sum    = r_sum;
    assign cout   = r_cout;
    assign err    = r_err;
    // Control FSM: latch operands on start, correct one digit per cycle, pulse done
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_c     <= 1'b0;
            r_cout  <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef BCD_SUB_EN
            r_sub   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_a     <= a;
                    r_b     <= b;
                    r_idx   <= '0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b1;
                    r_state <= ADD;
`ifdef BCD_SUB_EN
                    r_sub   <= sub;
                    r_c     <= sub | cin;
`else
                    r_c     <= cin;
`endif
                end
                ADD: begin
                    for (int i = 0; i < DIGITS; i++)
                        if (r_idx == IW'(i)) r_sum[4*i +: 4] <= w_s;
                    r_c   <= w_gt9;
                    r_err <= r_err | w_bad;
                    r_idx <= w_last ? '0 : r_idx + IW'(1);
                    if (w_last) begin
                        r_cout  <= w_gt9;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// tb_bcd_serial_adder_ctrl: randomized and directed checks of the digit-serial BCD adder against a digit-rule model
module tb_bcd_serial_adder_ctrl;
    localparam int DIGITS = 4;
    localparam int W = 4 * DIGITS;
    logic clk = 1'b0, resetn = 1'b0, start = 1'b0, cin = 1'b0, sub = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic busy, done, cout, err;
    logic [W-1:0] sum;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    bcd_serial_adder_ctrl #(.DIGITS(DIGITS)) dut (
        .clk(clk), .resetn(resetn), .start(start), .a(a), .b(b), .cin(cin),
`ifdef BCD_SUB_EN
        .sub(sub),
`endif
        .busy(busy), .done(done), .sum(sum), .cout(cout), .err(err)
    );

    // reference: returns {err, cout, sum} using decimal digit arithmetic
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic s);
        logic [W-1:0] r;
        int c, ad, bd, t;
        logic e;
        r = '0;
        e = 1'b0;
        c = s ? 1 : int'(ci);
        for (int i = 0; i < DIGITS; i++) begin
            ad = int'(x[4*i +: 4]);
            bd = int'(y[4*i +: 4]);
            if (ad > 9 || bd > 9) e = 1'b1;
            if (s) bd = (9 - bd) & 15;
            t = ad + bd + c;
            if (t > 9) begin
                r[4*i +: 4] = 4'((t + 6) % 16);
                c = 1;
            end else begin
                r[4*i +: 4] = 4'(t);
                c = 0;
            end
        end
        return {e, c[0], r};
    endfunction

    function automatic logic [W-1:0] rand_digits(input bit allow_bad);
        logic [W-1:0] v;
        for (int i = 0; i < DIGITS; i++)
            v[4*i +: 4] = (allow_bad && $urandom_range(0, 5) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        return v;
    endfunction

    // one operation; operands are scrambled right after the start edge
    task automatic do_op(input string nm, input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic s,
                         input logic [W-1:0] es, input logic ec, input logic ee);
        int n;
        @(negedge clk);
        a = x; b = y; cin = ci; sub = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        n = 1;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n !== DIGITS + 1) begin bad++; $display("FAIL %s latency: got %0d expected %0d", nm, n, DIGITS + 1); end
        total++;
        if (sum !== es) begin bad++; $display("FAIL %s sum: got %h expected %h", nm, sum, es); end
        total++;
        if (cout !== ec) begin bad++; $display("FAIL %s cout: got %b expected %b", nm, cout, ec); end
        total++;
        if (err !== ee) begin bad++; $display("FAIL %s err: got %b expected %b", nm, err, ee); end
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b1; a = 16'h1234; b = 16'h1111;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done, sum, cout, err} !== '0) begin bad++; $display("FAIL reset outputs: got %b_%b_%h_%b_%b expected all zero", busy, done, sum, cout, err); end
        resetn = 1'b1; start = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset start_ignored: got busy=%b expected 0", busy); end
    endtask

    task automatic test_plain_timing();
        @(negedge clk);
        a = 16'h1234; b = 16'h5678; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = '1; b = '1;
        for (int i = 0; i < DIGITS; i++) begin
            total++;
            if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL plain busy[%0d]: got busy=%b done=%b expected busy=1 done=0", i, busy, done); end
            @(negedge clk);
        end
        total++;
        if (busy !== 1'b0 || done !== 1'b1) begin bad++; $display("FAIL plain done: got busy=%b done=%b expected busy=0 done=1", busy, done); end
        total++;
        if ({err, cout, sum} !== {1'b0, 1'b0, 16'h6912}) begin bad++; $display("FAIL plain result: got %b %b %h expected 0 0 6912", err, cout, sum); end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || sum !== 16'h6912) begin bad++; $display("FAIL plain hold: got done=%b busy=%b sum=%h expected 0 0 6912", done, busy, sum); end
    endtask

    task automatic test_carry();
        do_op("ripple1", 16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op("ripple2", 16'h9999, 16'h9999, 1'b1, 1'b0, 16'h9999, 1'b1, 1'b0);
    endtask

    task automatic test_invalid();
        do_op("invalid", 16'h00A0, 16'h0000, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b1);
        do_op("err_clear", 16'h0011, 16'h0022, 1'b0, 1'b0, 16'h0033, 1'b0, 1'b0);
        do_op("invalid_b", 16'h0000, 16'hF000, 1'b0, 1'b0, 16'h5000, 1'b1, 1'b1);
    endtask

    task automatic test_random();
        logic [W-1:0] x, y;
        logic ci, s;
        logic [W+1:0] e;
        for (int k = 0; k < 30; k++) begin
            x = rand_digits(1'b1);
            y = rand_digits(1'b1);
            ci = 1'($urandom);
`ifdef BCD_SUB_EN
            s = 1'($urandom);
`else
            s = 1'b0;
`endif
            e = model(x, y, ci, s);
            do_op("random", x, y, ci, s, e[W-1:0], e[W], e[W+1]);
        end
    endtask

    task automatic test_back_to_back();
        int seen[$];
        int cyc;
        logic [W+1:0] e;
        e = model(16'h4321, 16'h2468, 1'b1, 1'b0);
        @(negedge clk);
        a = 16'h4321; b = 16'h2468; cin = 1'b1; sub = 1'b0; start = 1'b1;
        cyc = 0;
        while (seen.size() < 3 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                seen.push_back(cyc);
                total++;
                if (sum !== e[W-1:0] || cout !== e[W]) begin bad++; $display("FAIL b2b result: got %b %h expected %b %h", cout, sum, e[W], e[W-1:0]); end
            end
        end
        start = 1'b0;
        total++;
        if (seen.size() != 3) begin bad++; $display("FAIL b2b count: got %0d expected 3", seen.size()); end
        else begin
            total++;
            if (seen[1] - seen[0] != DIGITS + 2 || seen[2] - seen[1] != DIGITS + 2) begin
                bad++; $display("FAIL b2b spacing: got %0d,%0d expected %0d", seen[1] - seen[0], seen[2] - seen[1], DIGITS + 2);
            end
        end
        cyc = 0;
        while ((busy || done) && cyc < 20) begin @(negedge clk); cyc++; end
    endtask

    task automatic test_busy_start();
        int n;
        @(negedge clk);
        a = 16'h0102; b = 16'h0304; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 16'h9090; b = 16'h9090; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 20) begin @(negedge clk); n++; end
        total++;
        if (sum !== 16'h0406 || cout !== 1'b0) begin bad++; $display("FAIL busy_start result: got %b %h expected 0 0406", cout, sum); end
        repeat (2) @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL busy_start queued: got busy=%b expected 0", busy); end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        a = 16'h8888; b = 16'h1111; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, done, sum, cout, err} !== '0) begin bad++; $display("FAIL mid_reset outputs: got %b_%b_%h_%b_%b expected all zero", busy, done, sum, cout, err); end
        resetn = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL mid_reset idle: got busy=%b done=%b expected 0 0", busy, done); end
        do_op("after_reset", 16'h0005, 16'h0005, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0);
    endtask

`ifdef BCD_SUB_EN
    task automatic test_sub();
        do_op("sub1", 16'h0500, 16'h0123, 1'b0, 1'b1, 16'h0377, 1'b1, 1'b0);
        do_op("sub2", 16'h0100, 16'h0200, 1'b1, 1'b1, 16'h9900, 1'b0, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_plain_timing();
        test_carry();
        test_invalid();
        test_back_to_back();
        test_busy_start();
        test_mid_reset();
`ifdef BCD_SUB_EN
        test_sub();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bcd_serial_adder_ctrl.md
# bcd_serial_adder_ctrl

Sequential controller that adds two multi-digit packed-BCD operands one digit per clock. It shares a single 4-bit digit adder and one "greater than 9" decimal-correction comparator across all digit positions. It sits between the operand registers and the BCD display/decode path. It flags any operand digit that is not valid BCD (value above 9).

## Interface
Parameters:
- DIGITS, 4, number of BCD digits per operand (at least 1).

Ports:
- clk  in  1  rising-edge clock.
- resetn  in  1  synchronous, active-low reset, sampled on clk rising edge.
- start  in  1  request a new operation; sampled only in IDLE.
- a  in  4*DIGITS  packed BCD operand A; digit i is a[4i+3:4i].
- b  in  4*DIGITS  packed BCD operand B.
- cin  in  1  decimal carry-in.
- sub  in  1  subtract select; port exists only with BCD_SUB_EN.
- busy  out  1  high while digits are being processed.
- done  out  1  one-cycle pulse when results are valid.
- sum  out  4*DIGITS  packed BCD result.
- cout  out  1  decimal carry-out.
- err  out  1  sticky per operation: some input digit of a or b was above 9.

## Operation
- States:
  - IDLE: busy=0, done=0.
  - ADD: busy=1, one digit per cycle.
  - DONE: busy=0, done=1.
- IDLE to ADD when start=1:
  - a, b and cin are latched internally.
  - Digit index idx=0, carry register c=cin, err cleared to 0.
- ADD, each cycle, at idx:
  - t = a_idx + b_idx + c, computed as a 5-bit value in the range 0..31.
  - gt9 = t[4] | (t[3] & (t[2] | t[1])).
  - If gt9: sum digit idx = (t + 6) mod 16, c=1. Otherwise: sum digit idx = t[3:0], c=0.
  - If a_idx > 9 or b_idx > 9, err is set. The same comparator rule is applied to each input digit.
  - An invalid digit is still processed by the rule above; no saturation.
  - idx increments each cycle. After the digit with idx=DIGITS-1, c goes to cout and the state moves to DONE.
- DONE always returns to IDLE on the next cycle.
- start is ignored in ADD and DONE, and is not queued.
- sum, cout and err hold their values from DONE until the next accepted start.
- sum digits not yet processed in the current operation keep their previous values until overwritten.

## Timing
- Reset values (resetn=0 at any edge, including mid-operation):
  - State IDLE, busy=0, done=0, sum=0, cout=0, err=0, idx=0, c=0.
  - The operation in progress is abandoned.
- If start is sampled at edge k: busy=1 from k through k+DIGITS, and done=1 for exactly the cycle after edge k+DIGITS.
- Latency from the start edge to done is DIGITS+1 cycles.
- The earliest next start is accepted in the IDLE cycle after done, giving a throughput of one operation per DIGITS+2 cycles.
- Inputs a, b, cin and sub may change freely after the start edge.
- resetn and start asserted in the same cycle: reset wins.

## Configuration
- Macro BCD_SUB_EN.
- Defined:
  - The sub port exists and is latched with the operands at start.
  - If sub=1, each b digit is replaced by its nine's complement (9 - b_i) mod 16, and the initial carry is forced to 1 (cin ignored). The result is a - b in ten's complement.
  - cout=1 means no borrow (a ≥ b). cout=0 means a borrow occurred, and sum holds the ten's complement of the difference.
  - err is evaluated on the original b digit, not its complement.
- Undefined: there is no sub port, and the block performs addition only.

## Test plan
- Plain add, DIGITS=4: a=0x1234, b=0x5678, cin=0, start pulsed at edge k. Required: busy high for edges k..k+4, done high for one cycle after edge k+4, sum=0x6912, cout=0, err=0.
- Full carry ripple: a=0x9999, b=0x0001, cin=0 gives sum=0x0000, cout=1. Then a=0x9999, b=0x9999, cin=1 gives sum=0x9999, cout=1.
- Invalid digit: a=0x00A0, b=0x0000, cin=0 gives sum=0x0100, cout=0, err=1. The next operation with valid operands must clear err to 0.
- Handshake robustness:
  - Hold start high continuously. Operations must occur back-to-back, with start accepted every 6 cycles.
  - A start pulse during busy has no effect.
- Reset mid-operation: assert resetn=0 two cycles after start. All outputs must be 0 on the next edge and the block must be in IDLE. A subsequent add of 0x0005+0x0005 gives sum=0x0010.
- With BCD_SUB_EN, sub=1:
  - a=0x0500, b=0x0123 gives sum=0x0377, cout=1.
  - a=0x0100, b=0x0200 gives sum=0x9900, cout=0.
